// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS pipeline: control-bundle width, the bit
//   position of each control field, ALU operation encodings and the packed
//   control-bundle type.
//   No ports (package).
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int CTRL_W = 9;

    // Bit positions inside the 9-bit control bundle
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_TO_REG = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_REG_DST    = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/pipe_field_reg.sv
// ----------------------------------------------------------------------------
// pipe_field_reg
//   W-bit pipeline field register with synchronous reset, clear and load.
//   Priority per edge: rst > clr > load > hold. Clear zeroes the field.
// Ports
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous active-high reset
//   load  in  1  capture d
//   clr   in  1  zero the field (beats load)
//   d     in  W  next value
//   q     out W  registered value
// ----------------------------------------------------------------------------
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)       q <= '0;
        else if (clr)  q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline stage register. Latches decode outputs for the execute
//   stage with a valid/ready handshake, flush, and bubble insertion (a bubble
//   carries an all-zero control bundle so EX cannot commit anything).
//   Optional feature macro: ID_EX_BUBBLE_CNT_EN adds a saturating bubble
//   counter and the ex_bubble_cnt port.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   flush                       squash stage contents, drop incoming instr
//   id_valid / id_ready         upstream handshake (id_ready combinational)
//   id_pc_plus4, id_rs_data,
//   id_rt_data, id_sign_ext     DATA_W decode data
//   id_rs, id_rt, id_rd         REG_ADDR_W register specifiers
//   id_ctrl                     9-bit control bundle
//   ex_ready / ex_valid         downstream handshake
//   ex_*                        registered copies of id_*
//   ex_bubble_cnt               CNT_W bubble count (macro only)
// ----------------------------------------------------------------------------
module id_ex_pipe_reg
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_sign_ext,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_sign_ext,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]     ex_ctrl
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]      ex_bubble_cnt
`endif
);

    localparam int DB_W = 4*DATA_W + 3*REG_ADDR_W;

    logic            transfer;
    logic            drain;
    logic            valid_nxt;
    logic [DB_W-1:0] data_d;
    logic [DB_W-1:0] data_q;
    ctrl_t           ctrl_d;
    ctrl_t           ctrl_q;

    assign id_ready = !ex_valid || ex_ready;
    assign transfer = id_valid && id_ready;
    assign drain    = ex_valid && ex_ready && !id_valid;

    // Occupancy (EMPTY/FULL) is just ex_valid; flush wins over a transfer.
    always_comb begin
        valid_nxt = ex_valid;
        if (flush)         valid_nxt = 1'b0;
        else if (transfer) valid_nxt = 1'b1;
        else if (drain)    valid_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) ex_valid <= 1'b0;
        else     ex_valid <= valid_nxt;
    end

    // Data fields are not cleared on flush/drain; only ctrl must go to zero.
    assign data_d = {id_pc_plus4, id_rs_data, id_rt_data, id_sign_ext,
                     id_rs, id_rt, id_rd};

    pipe_field_reg #(.W(DB_W)) u_data (
        .clk  (clk),
        .rst  (rst),
        .load (transfer && !flush),
        .clr  (1'b0),
        .d    (data_d),
        .q    (data_q)
    );

    assign {ex_pc_plus4, ex_rs_data, ex_rt_data, ex_sign_ext,
            ex_rs, ex_rt, ex_rd} = data_q;

    assign ctrl_d = ctrl_t'(id_ctrl);

    // Clear beats load inside the field register, so a flushed transfer
    // leaves a bubble. Drain and transfer are mutually exclusive.
    pipe_field_reg #(.W(CTRL_W)) u_ctrl (
        .clk  (clk),
        .rst  (rst),
        .load (transfer),
        .clr  (flush || drain),
        .d    (ctrl_d),
        .q    (ctrl_q)
    );

    assign ex_ctrl = ctrl_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    // Counts every edge that leaves the stage empty; saturates.
    always_ff @(posedge clk) begin
        if (rst)
            ex_bubble_cnt <= '0;
        else if (!valid_nxt && (ex_bubble_cnt != {CNT_W{1'b1}}))
            ex_bubble_cnt <= ex_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          id_valid;
    logic          id_ready;
    logic [DW-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_sign_ext;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [8:0]    id_ctrl;
    logic          ex_ready;
    logic          ex_valid;
    logic [DW-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_sign_ext;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [8:0]    ex_ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CW-1:0] ex_bubble_cnt;
`endif

    id_ex_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc_plus4 (id_pc_plus4),
        .id_rs_data  (id_rs_data),
        .id_rt_data  (id_rt_data),
        .id_sign_ext (id_sign_ext),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_ctrl     (id_ctrl),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_pc_plus4 (ex_pc_plus4),
        .ex_rs_data  (ex_rs_data),
        .ex_rt_data  (ex_rt_data),
        .ex_sign_ext (ex_sign_ext),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_ctrl     (ex_ctrl)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .ex_bubble_cnt (ex_bubble_cnt)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] rsd;
        logic [DW-1:0] rtd;
        logic [DW-1:0] se;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [8:0]    ctrl;
    } txn_t;

    txn_t          sb[$];      // instruction currently owned by the stage
    txn_t          last_acc;   // most recently accepted instruction
    logic [CW-1:0] bcnt_m;
    bit            started = 0;
    int            passed  = 0;
    int            total   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [151:0] act, input logic [151:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic txn_t id_txn();
        txn_t t;
        t.pc = id_pc_plus4; t.rsd = id_rs_data; t.rtd = id_rt_data; t.se = id_sign_ext;
        t.rs = id_rs; t.rt = id_rt; t.rd = id_rd; t.ctrl = id_ctrl;
        return t;
    endfunction

    function automatic txn_t ex_txn();
        txn_t t;
        t.pc = ex_pc_plus4; t.rsd = ex_rs_data; t.rtd = ex_rt_data; t.se = ex_sign_ext;
        t.rs = ex_rs; t.rt = ex_rt; t.rd = ex_rd; t.ctrl = ex_ctrl;
        return t;
    endfunction

    // Reference model: a one-deep queue of the instruction held by the stage.
    always @(posedge clk) begin
        bit acc;
        started = 1;
        if (rst) begin
            sb.delete();
            last_acc = '0;
            bcnt_m   = '0;
        end else begin
            acc = id_valid && (sb.size() == 0 || ex_ready);
            if (flush) begin
                sb.delete();
            end else begin
                if (sb.size() != 0 && ex_ready) void'(sb.pop_front());
                if (acc) begin
                    last_acc = id_txn();
                    sb.push_back(last_acc);
                end
            end
            if (sb.size() == 0 && bcnt_m != {CW{1'b1}}) bcnt_m = bcnt_m + 1'b1;
        end
    end

    // Monitor: compare presented output against the scoreboard head.
    always @(negedge clk) begin
        txn_t exp;
        if (started) begin
            check("ex_valid", 152'(ex_valid), 152'(sb.size() != 0));
            check("id_ready", 152'(id_ready), 152'(sb.size() == 0 || ex_ready));
            if (sb.size() != 0) begin
                check("payload", ex_txn(), sb[0]);
            end else begin
                exp = last_acc;
                exp.ctrl = '0;
                check("bubble", ex_txn(), exp);
            end
`ifdef ID_EX_BUBBLE_CNT_EN
            check("bubble_cnt", 152'(ex_bubble_cnt), 152'(bcnt_m));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_fields();
        id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
        id_sign_ext = $urandom; id_rs = AW'($urandom); id_rt = AW'($urandom);
        id_rd = AW'($urandom); id_ctrl = 9'($urandom);
    endtask

    initial begin
        logic [DW-1:0] imms [4];
        logic [DW-1:0] prev_se;
        imms[0] = 32'h00000007; imms[1] = 32'hFFFFFFF8;
        imms[2] = 32'h00000000; imms[3] = 32'hFFFF8000;

        // Reset with a valid instruction presented
        rst = 1; flush = 0; ex_ready = 1; id_valid = 1;
        rand_fields();
        id_sign_ext = 32'hFFFFF234;
        tick(); tick();
        check("rst_valid",   152'(ex_valid),    152'(0));
        check("rst_sign",    152'(ex_sign_ext), 152'(0));
        check("rst_ctrl",    152'(ex_ctrl),     152'(0));
        check("rst_idready", 152'(id_ready),    152'(1));
        rst = 0; id_valid = 0;

`ifdef ID_EX_BUBBLE_CNT_EN
        repeat (20) tick();
        check("cnt_sat", 152'(ex_bubble_cnt), 152'(4'hF));
        rst = 1;
        tick();
        check("cnt_rst", 152'(ex_bubble_cnt), 152'(0));
        rst = 0;
`endif

        // Pass-through
        rand_fields();
        id_sign_ext = 32'h00001234; id_ctrl = 9'h1A2; id_valid = 1; ex_ready = 1;
        tick();
        check("pt_sign",  152'(ex_sign_ext), 152'(32'h00001234));
        check("pt_ctrl",  152'(ex_ctrl),     152'(9'h1A2));
        check("pt_valid", 152'(ex_valid),    152'(1));
        id_valid = 0;
        tick();

        // Stall
        rand_fields();
        id_rs_data = 32'hDEADBEEF; id_valid = 1; ex_ready = 1;
        tick();
        ex_ready = 0;
        rand_fields();
        id_rs_data = 32'h11111111;
        #1;
        check("stall_idready0", 152'(id_ready), 152'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold",    152'(ex_rs_data), 152'(32'hDEADBEEF));
            check("stall_idready", 152'(id_ready),   152'(0));
        end
        ex_ready = 1;
        tick();
        check("stall_release", 152'(ex_rs_data), 152'(32'h11111111));

        // Flush while a transfer is offered
        prev_se = ex_sign_ext;
        rand_fields();
        id_sign_ext = 32'hABCD0000; id_ctrl = 9'h1FF;
        flush = 1; id_valid = 1; ex_ready = 1;
        tick();
        check("flush_valid", 152'(ex_valid),    152'(0));
        check("flush_ctrl",  152'(ex_ctrl),     152'(0));
        check("flush_sign",  152'(ex_sign_ext), 152'(prev_se));
        flush = 0; id_valid = 0;
        tick();

        // Back-to-back
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            id_sign_ext = imms[i]; id_valid = 1; ex_ready = 1;
            tick();
            check("b2b_sign",  152'(ex_sign_ext), 152'(imms[i]));
            check("b2b_valid", 152'(ex_valid),    152'(1));
        end
        id_valid = 0;
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            id_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 0; flush = 0; id_valid = 0; ex_ready = 1;
        tick(); tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
